// File: rtl/sprite_scan_arbiter_if.sv
// Bundle of the sprite_scan_arbiter signals: the print-pipeline lookup port,
// the CPU write port and the single-port sprite register bank port.
//   master : drives lookup requests, CPU writes and bank read data
//   slave  : the arbiter; returns lookup results, acks writes, drives the bank
interface sprite_scan_arbiter_if #(
    parameter int SPR_IDX = 5,
    parameter int XY_W    = 20
);
    logic [XY_W-1:0]    check_value;
    logic               scan_start;
    logic [31:0]        data_reg;
    logic               data_valid;
    logic               busy;
    logic               cpu_wr_req;
    logic [SPR_IDX-1:0] cpu_wr_addr;
    logic [31:0]        cpu_wr_data;
    logic               cpu_wr_ack;
    logic [SPR_IDX-1:0] bank_addr;
    logic [31:0]        bank_rd_data;
    logic               bank_wr_en;
    logic [31:0]        bank_wr_data;

    modport master (
        output check_value, scan_start, cpu_wr_req, cpu_wr_addr, cpu_wr_data,
               bank_rd_data,
        input  data_reg, data_valid, busy, cpu_wr_ack, bank_addr, bank_wr_en,
               bank_wr_data
    );

    modport slave (
        input  check_value, scan_start, cpu_wr_req, cpu_wr_addr, cpu_wr_data,
               bank_rd_data,
        output data_reg, data_valid, busy, cpu_wr_ack, bank_addr, bank_wr_en,
               bank_wr_data
    );
endinterface

// File: rtl/sprite_scan_arbiter.sv
// Shared-access controller for the sprite register bank. Coordinate lookups
// scan the bank in index order and return the first enabled sprite covering
// the pixel (or background code 32'h1); CPU writes are slotted in between
// scans, with one guaranteed write slot after every scan.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : sprite_scan_arbiter_if.slave (lookup, CPU write, bank signals)
//
// state | meaning
// IDLE  | waiting; serves a scan (new or pending) first, else a CPU write
// SCAN  | bank_addr = idx, testing one sprite per cycle
// DONE  | data_valid pulse; hands the next slot to a waiting CPU write
// WRITE | single bank write cycle with cpu_wr_ack
module sprite_scan_arbiter #(
    parameter int NUM_SPRITES = 32,
    parameter int SPR_IDX     = 5,
    parameter int bits_x_y    = 20,
    parameter int SPRITE_SIZE = 20
) (
    input  logic                   clk,
    input  logic                   reset,
    sprite_scan_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE, WRITE} state_t;

    localparam logic [31:0]        BG_CODE  = 32'h0000_0001;
    localparam logic [SPR_IDX-1:0] LAST_IDX = SPR_IDX'(NUM_SPRITES - 1);
    localparam logic [10:0]        EDGE_M1  = 11'(SPRITE_SIZE - 1);

    state_t              state_q, state_d;
    logic [SPR_IDX-1:0]  idx_q, idx_d;
    logic [bits_x_y-1:0] scan_coord_q, scan_coord_d;
    logic [bits_x_y-1:0] pend_coord_q, pend_coord_d;
    logic                pend_q, pend_d;
    logic [31:0]         data_reg_q, data_reg_d;

    logic                data_valid;
    logic                wr_ack;
    logic [SPR_IDX-1:0]  bank_addr;
    logic [31:0]         bank_wr_data;

    // Comparisons run 11 bits wide so a sprite near the right/bottom edge
    // covers up to pixel 1023 instead of wrapping back to small coordinates.
    logic [10:0] px, py, x0, y0;
    logic        hit;

    always_comb begin
        px  = {1'b0, scan_coord_q[19:10]};
        py  = {1'b0, scan_coord_q[9:0]};
        x0  = {1'b0, bus.bank_rd_data[28:19]};
        y0  = {1'b0, bus.bank_rd_data[18:9]};
        hit = bus.bank_rd_data[29]
              && (px >= x0) && (px <= x0 + EDGE_M1)
              && (py >= y0) && (py <= y0 + EDGE_M1);
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        scan_coord_d = scan_coord_q;
        pend_coord_d = pend_coord_q;
        pend_d       = pend_q;
        data_reg_d   = data_reg_q;
        data_valid   = 1'b0;
        wr_ack       = 1'b0;
        bank_addr    = '0;
        bank_wr_data = '0;

        // Requests arriving while busy are parked; a later one replaces
        // the coordinate of an earlier unserved one.
        if (bus.scan_start && state_q != IDLE) begin
            pend_d       = 1'b1;
            pend_coord_d = bus.check_value;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.scan_start || pend_q) begin
                    state_d      = SCAN;
                    idx_d        = '0;
                    scan_coord_d = bus.scan_start ? bus.check_value : pend_coord_q;
                    pend_d       = 1'b0;
                end else if (bus.cpu_wr_req) begin
                    state_d = WRITE;
                end
            end
            SCAN: begin
                bank_addr = idx_q;
                if (hit) begin
                    data_reg_d = bus.bank_rd_data;
                    state_d    = DONE;
                end else if (idx_q == LAST_IDX) begin
                    data_reg_d = BG_CODE;
                    state_d    = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                data_valid = 1'b1;
                state_d    = bus.cpu_wr_req ? WRITE : IDLE;
            end
            WRITE: begin
                wr_ack       = 1'b1;
                bank_addr    = bus.cpu_wr_addr;
                bank_wr_data = bus.cpu_wr_data;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            scan_coord_q <= '0;
            pend_coord_q <= '0;
            pend_q       <= 1'b0;
            data_reg_q   <= BG_CODE;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            scan_coord_q <= scan_coord_d;
            pend_coord_q <= pend_coord_d;
            pend_q       <= pend_d;
            data_reg_q   <= data_reg_d;
        end
    end

    assign bus.data_reg     = data_reg_q;
    assign bus.data_valid   = data_valid;
    assign bus.busy         = (state_q != IDLE) || pend_q;
    assign bus.cpu_wr_ack   = wr_ack;
    assign bus.bank_wr_en   = wr_ack;
    assign bus.bank_addr    = bank_addr;
    assign bus.bank_wr_data = bank_wr_data;
endmodule

// File: tb/tb_sprite_scan_arbiter.sv
module tb_sprite_scan_arbiter;
    localparam int N = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    sprite_scan_arbiter_if #(.SPR_IDX(5), .XY_W(20)) sif ();

    sprite_scan_arbiter #(
        .NUM_SPRITES(N), .SPR_IDX(5), .bits_x_y(20), .SPRITE_SIZE(20)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (sif.slave)
    );

    // Register bank outside the DUT: combinational read, write on the edge.
    logic [31:0] bank [0:N-1];
    assign sif.bank_rd_data = bank[sif.bank_addr];
    always @(posedge clk) if (sif.bank_wr_en) bank[sif.bank_addr] <= sif.bank_wr_data;

    int tests = 0;
    int errors = 0;
    bit started = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] spr(input bit en, input int x, input int y,
                                        input int off, input logic [1:0] hi);
        logic [31:0] w;
        w = {hi, en, 10'(x), 10'(y), 9'(off)};
        return w;
    endfunction

    function automatic logic [19:0] xy(input int px, input int py);
        logic [19:0] c;
        c = {10'(px), 10'(py)};
        return c;
    endfunction

    // ---------------- behavioural reference model ----------------
    // Transaction view: a lookup occupies (winning index + 1) scan cycles,
    // or N on a miss; the result is found by searching the model's copy of
    // the bank with plain integer range checks.
    typedef enum {M_IDLE, M_SCAN, M_DONE, M_WRITE} mph_t;
    mph_t        m_ph = M_IDLE;
    int          m_left = 0;
    int          m_len = 0;
    logic [31:0] m_res = 32'h1;
    logic [31:0] m_data = 32'h1;
    bit          m_pend = 0;
    logic [19:0] m_pcoord = '0;
    logic [31:0] mbank [0:N-1];

    task automatic search(input logic [19:0] c, output logic [31:0] res, output int len);
        int px, py, x, y;
        px = int'(c[19:10]);
        py = int'(c[9:0]);
        res = 32'h1;
        len = N;
        for (int i = N - 1; i >= 0; i--) begin
            x = int'(mbank[i][28:19]);
            y = int'(mbank[i][18:9]);
            if (mbank[i][29] && px >= x && px < x + 20 && py >= y && py < y + 20) begin
                res = mbank[i];
                len = i + 1;
            end
        end
    endtask

    task automatic model_step();
        mph_t cur;
        cur = m_ph;
        if (sif.scan_start && cur != M_IDLE) begin
            m_pend   = 1;
            m_pcoord = sif.check_value;
        end
        case (cur)
            M_IDLE: begin
                if (sif.scan_start || m_pend) begin
                    search(sif.scan_start ? sif.check_value : m_pcoord, m_res, m_len);
                    m_pend = 0;
                    m_left = m_len;
                    m_ph   = M_SCAN;
                end else if (sif.cpu_wr_req) begin
                    m_ph = M_WRITE;
                end
            end
            M_SCAN: begin
                m_left--;
                if (m_left == 0) begin
                    m_ph   = M_DONE;
                    m_data = m_res;
                end
            end
            M_DONE:  m_ph = sif.cpu_wr_req ? M_WRITE : M_IDLE;
            M_WRITE: begin
                mbank[sif.cpu_wr_addr] = sif.cpu_wr_data;
                m_ph = M_IDLE;
            end
        endcase
    endtask

    task automatic model_reset();
        m_ph = M_IDLE;
        m_pend = 0;
        m_data = 32'h1;
        m_left = 0;
        m_len = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (started) begin
            chk("data_reg", sif.data_reg, m_data);
            chk("data_valid", 32'(sif.data_valid), 32'(m_ph == M_DONE));
            chk("busy", 32'(sif.busy), 32'(m_ph != M_IDLE || m_pend));
            chk("cpu_wr_ack", 32'(sif.cpu_wr_ack), 32'(m_ph == M_WRITE));
            chk("bank_wr_en", 32'(sif.bank_wr_en), 32'(m_ph == M_WRITE));
            chk("bank_addr", 32'(sif.bank_addr),
                m_ph == M_WRITE ? 32'(sif.cpu_wr_addr) :
                m_ph == M_SCAN  ? 32'(m_len - m_left) : 32'd0);
            chk("bank_wr_data", sif.bank_wr_data,
                m_ph == M_WRITE ? sif.cpu_wr_data : 32'd0);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic cpu_write(input string nm, input int addr, input logic [31:0] data);
        int cnt;
        bit seen;
        cnt = 0;
        seen = 0;
        @(negedge clk);
        #1;
        sif.cpu_wr_req  = 1'b1;
        sif.cpu_wr_addr = 5'(addr);
        sif.cpu_wr_data = data;
        while (!seen && cnt < 50) begin
            @(negedge clk);
            cnt++;
            if (sif.cpu_wr_ack) seen = 1;
            #1;
        end
        sif.cpu_wr_req = 1'b0;
        chk(nm, 32'(cnt), 32'd1);
    endtask

    task automatic lookup(input string nm, input logic [19:0] c,
                          input logic [31:0] exp_word, input int exp_lat);
        int cnt;
        bit seen;
        cnt = 0;
        seen = 0;
        @(negedge clk);
        #1;
        sif.scan_start  = 1'b1;
        sif.check_value = c;
        while (!seen && cnt < 100) begin
            @(negedge clk);
            cnt++;
            if (sif.data_valid) seen = 1;
            #1;
            sif.scan_start = 1'b0;
        end
        chk({nm, "_latency"}, 32'(cnt - 1), 32'(exp_lat));
        chk({nm, "_data"}, sif.data_reg, exp_word);
    endtask

    function automatic logic [19:0] rand_coord();
        if ($urandom_range(0, 9) == 0)
            return xy($urandom_range(1000, 1023), $urandom_range(0, 90));
        return xy($urandom_range(0, 90), $urandom_range(0, 90));
    endfunction

    function automatic logic [31:0] rand_sprite();
        int x;
        x = ($urandom_range(0, 7) == 0) ? $urandom_range(1000, 1023) : $urandom_range(0, 70);
        return spr($urandom_range(0, 3) != 0, x, $urandom_range(0, 70),
                   $urandom_range(0, 511), 2'($urandom_range(0, 3)));
    endfunction

    logic [31:0] s3, s2, s2_off, s7, s10;

    initial begin
        int dv1, dv2, ackc, hold, dvcnt, wrcnt;
        logic [31:0] d1, d2;
        bit ack_now;

        for (int i = 0; i < N; i++) begin
            bank[i]  = '0;
            mbank[i] = '0;
        end
        sif.scan_start  = 1'b0;
        sif.check_value = '0;
        sif.cpu_wr_req  = 1'b0;
        sif.cpu_wr_addr = '0;
        sif.cpu_wr_data = '0;

        #2 rst_n = 1'b0;
        started = 1;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_data_reg", sif.data_reg, 32'h1);
        chk("rst_busy", 32'(sif.busy), 32'd0);
        chk("rst_data_valid", 32'(sif.data_valid), 32'd0);
        chk("rst_bank_wr_en", 32'(sif.bank_wr_en), 32'd0);

        s3     = spr(1, 100, 50, 5, 2'b00);
        s2     = spr(1, 190, 195, 7, 2'b01);
        s2_off = spr(0, 190, 195, 7, 2'b01);
        s7     = spr(1, 200, 200, 9, 2'b10);
        s10    = spr(1, 1015, 0, 3, 2'b11);

        cpu_write("wr_s3_ack_lat", 3, s3);
        lookup("hit_s3", xy(105, 60), s3, 4);
        cpu_write("wr_s2_ack_lat", 2, s2);
        cpu_write("wr_s7_ack_lat", 7, s7);
        lookup("prio_s2", xy(200, 200), s2, 3);
        cpu_write("wr_s2off_ack_lat", 2, s2_off);
        lookup("prio_s7", xy(200, 200), s7, 8);
        lookup("edge_in", xy(119, 60), s3, 4);
        lookup("edge_out", xy(120, 60), 32'h1, N);
        cpu_write("wr_s10_ack_lat", 10, s10);
        lookup("nowrap", xy(1023, 5), s10, 11);

        // Simultaneous scan + write, with two requests landing during SCAN.
        dv1 = 0; dv2 = 0; ackc = 0; d1 = '0; d2 = '0;
        @(negedge clk);
        #1;
        sif.scan_start  = 1'b1;
        sif.check_value = xy(105, 60);
        sif.cpu_wr_req  = 1'b1;
        sif.cpu_wr_addr = 5'd20;
        sif.cpu_wr_data = 32'h0000_0123;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (sif.data_valid) begin
                if (dv1 == 0) begin dv1 = k; d1 = sif.data_reg; end
                else if (dv2 == 0) begin dv2 = k; d2 = sif.data_reg; end
            end
            ack_now = sif.cpu_wr_ack;
            if (ack_now && ackc == 0) ackc = k;
            #1;
            if (k == 1) sif.check_value = xy(300, 300);
            if (k == 2) sif.check_value = xy(205, 210);
            if (k == 3) sif.scan_start = 1'b0;
            if (ack_now) sif.cpu_wr_req = 1'b0;
        end
        chk("conc_dv1_cycle", 32'(dv1), 32'd5);
        chk("conc_dv1_data", d1, s3);
        chk("conc_ack_cycle", 32'(ackc), 32'd6);
        chk("conc_dv2_cycle", 32'(dv2), 32'd16);
        chk("conc_dv2_data", d2, s7);

        // Reset five cycles into a miss scan with a request pending.
        @(negedge clk);
        #1;
        sif.scan_start  = 1'b1;
        sif.check_value = xy(300, 300);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            #1;
            sif.scan_start = (k == 3);
            if (k == 3) sif.check_value = xy(105, 60);
        end
        rst_n = 1'b0;
        #2;
        chk("mid_rst_data_reg", sif.data_reg, 32'h1);
        chk("mid_rst_busy", 32'(sif.busy), 32'd0);
        chk("mid_rst_data_valid", 32'(sif.data_valid), 32'd0);
        chk("mid_rst_bank_wr_en", 32'(sif.bank_wr_en), 32'd0);
        chk("mid_rst_bank_addr", 32'(sif.bank_addr), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        dvcnt = 0;
        wrcnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (sif.data_valid) dvcnt++;
            if (sif.bank_wr_en) wrcnt++;
        end
        chk("post_rst_data_valid_count", 32'(dvcnt), 32'd0);
        chk("post_rst_bank_wr_count", 32'(wrcnt), 32'd0);
        chk("post_rst_busy", 32'(sif.busy), 32'd0);

        // Randomized traffic checked by the model every cycle.
        hold = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            ack_now = sif.cpu_wr_ack;
            #1;
            sif.scan_start = (c < 3900) && ($urandom_range(0, 7) == 0);
            if (sif.scan_start) sif.check_value = rand_coord();
            if (sif.cpu_wr_req) begin
                if (ack_now) sif.cpu_wr_req = 1'b0;
                else begin
                    hold++;
                    if (hold > 200) begin
                        tests++;
                        errors++;
                        $display("FAIL cpu_wr_wait actual=%0d cycles required<=200", hold);
                        sif.cpu_wr_req = 1'b0;
                    end
                end
            end else if (c < 3900 && $urandom_range(0, 5) == 0) begin
                sif.cpu_wr_addr = 5'($urandom_range(0, N - 1));
                sif.cpu_wr_data = rand_sprite();
                sif.cpu_wr_req  = 1'b1;
                hold = 0;
            end
        end
        sif.cpu_wr_req = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
